// File: rtl/piso_feeder.sv
// piso_feeder: parallel-in / serial-out feeder for the siso serial line.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per
// clock. A one-word holding register lets words stream back to back.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   din, din_valid    parallel word and its valid
//   din_ready         feeder can take a word (combinational, from hold_full/rst_n)
//   sout, sout_valid  registered serial bit and its valid
//   frame_start       registered, high while the first bit of a word is on sout
//   busy              registered, a word is shifting or waiting in hold
module piso_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_full;
  logic               r_sout;
  logic               r_sout_valid;
  logic               r_frame_start;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_hold_nxt;
  logic               w_hold_full_nxt;
  logic [WIDTH-1:0]   w_shift_adv;
  logic               w_accept;
  logic               w_last;
  logic               w_bit_nxt;

  // Ready depends only on the holding register, never on din_valid.
  assign din_ready = rst_n & ~r_hold_full;
  assign w_accept  = din_valid & ~r_hold_full;
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);

  // Shifter advance moves the next bit toward the output end.
  assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};

  // Next-state and datapath routing.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = din;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_shift_nxt = w_shift_adv;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (w_accept) begin
            w_hold_nxt      = din;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_bit_nxt = (MSB_FIRST != 0) ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];

  // State and registered outputs; outputs derive from next-state values so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_sout        <= 1'b0;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_sout        <= (w_state_nxt == ST_SHIFT) & w_bit_nxt;
      r_sout_valid  <= (w_state_nxt == ST_SHIFT);
      r_frame_start <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == '0);
      r_busy        <= (w_state_nxt == ST_SHIFT) | w_hold_full_nxt;
    end
  end

  assign sout        = r_sout;
  assign sout_valid  = r_sout_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_piso_feeder.sv
// Testbench for piso_feeder: one MSB-first and one LSB-first instance share
// stimulus; a bit-queue model predicts every serial cycle.
module tb_piso_feeder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;

  logic m_ready, m_sout, m_valid, m_fs, m_busy;
  logic l_ready, l_sout, l_valid, l_fs, l_busy;

  piso_feeder #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
    .frame_start(m_fs), .busy(m_busy)
  );

  piso_feeder #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
    .frame_start(l_fs), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  logic model_ready = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // A word accepted on the coming edge appends its bits in line order.
  function automatic void push_word(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      q_m.push_back('{b: w[W-1-k], fs: (k == 0)});
      q_l.push_back('{b: w[k],     fs: (k == 0)});
    end
  endfunction

  // Monitor: each cycle the line shows the next queued bit, or idles.
  always @(negedge clk) begin
    exp_t e;
    logic v;
    if (!rst_n) begin
      q_m.delete();
      q_l.delete();
      model_ready = 1'b0;
      chk("rst_m_valid", m_valid, 1'b0); chk("rst_m_sout", m_sout, 1'b0);
      chk("rst_m_fs", m_fs, 1'b0);       chk("rst_m_busy", m_busy, 1'b0);
      chk("rst_m_ready", m_ready, 1'b0);
      chk("rst_l_valid", l_valid, 1'b0); chk("rst_l_ready", l_ready, 1'b0);
    end else begin
      if (q_m.size() > 0) begin e = q_m.pop_front(); v = 1'b1; end
      else begin e = '0; v = 1'b0; end
      chk("m_valid", m_valid, v);
      chk("m_sout", m_sout, e.b);
      chk("m_fs", m_fs, e.fs);
      chk("m_busy", m_busy, v | (q_m.size() >= W));
      chk("m_ready", m_ready, q_m.size() < W);

      if (q_l.size() > 0) begin e = q_l.pop_front(); v = 1'b1; end
      else begin e = '0; v = 1'b0; end
      chk("l_valid", l_valid, v);
      chk("l_sout", l_sout, e.b);
      chk("l_fs", l_fs, e.fs);
      chk("l_busy", l_busy, v | (q_l.size() >= W));
      chk("l_ready", l_ready, q_l.size() < W);

      model_ready = (q_m.size() < W);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Hold din_valid until the model says the word is taken (bounded).
  task automatic send(input logic [W-1:0] w);
    bit done = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int t = 0; t < 4 * W && !done; t++) begin
      if (model_ready) begin
        push_word(w);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    idle(2);

    // Single word, then back-to-back pair with valid held.
    send(8'hA5);
    idle(12);
    send(8'hA5);
    send(8'h3C);
    idle(20);

    // LSB-first order shows 1 then seven zeros on the second instance.
    send(8'h01);
    idle(12);

    // Next word offered exactly on the last-bit edge with hold empty.
    send(8'h00);
    idle(7);
    send(8'hFF);
    idle(12);

    // Asynchronous reset mid-word while hold is occupied.
    send(8'hFF);
    send(8'h0F);
    din_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 1'b0); chk("async_m_sout", m_sout, 1'b0);
    chk("async_m_fs", m_fs, 1'b0);       chk("async_m_busy", m_busy, 1'b0);
    chk("async_m_ready", m_ready, 1'b0);
    chk("async_l_valid", l_valid, 1'b0); chk("async_l_busy", l_busy, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    idle(12);

    // Randomized traffic with random valid gaps.
    for (int i = 0; i < 600; i++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      if (din_valid && model_ready) push_word(din);
      step();
    end
    idle(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_feeder.md
# piso_feeder

Parallel-in, serial-out feeder placed directly upstream of the `siso` shift register. It accepts parallel words over a valid/ready handshake and drives one bit per clock onto the serial line that connects to the `siso` `sin` input. A one-word holding register lets consecutive words stream with no idle bit between them. The serial output is fully registered, so the `siso` stage samples a clean, glitch-free bit every cycle.

## Interface

- `WIDTH`, default 8: bits per word; legal range is WIDTH >= 2.
- `MSB_FIRST`, default 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word to serialize.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  feeder can accept a word this cycle.
- `sout`  out  WIDTH-independent 1  serial bit; connects to `siso.sin`.
- `sout_valid`  out  1  `sout` carries a data bit this cycle.
- `frame_start`  out  1  high for the cycle that carries bit 0 of each word.
- `busy`  out  1  a word is being shifted or is waiting in the holding register.

## Operation

- Storage:
  - WIDTH-bit shift register.
  - Bit counter, `cnt`, of width clog2(WIDTH).
  - WIDTH-bit holding register `hold` with flag `hold_full`.
- Two states:
  - IDLE: shifter empty.
  - SHIFT: a word is on the line.
- Handshake: a word is accepted on any rising edge where `din_valid && din_ready`. `din_ready = rst_n && !hold_full`.
- Accepted word routing on that edge:
  - In IDLE, the word loads directly into the shifter. `cnt` is set to 0 and the state moves to SHIFT.
  - In SHIFT with `cnt == WIDTH-1` (last bit) and `hold_full == 0`, the word loads directly into the shifter. `cnt` is set to 0 and the state stays SHIFT.
  - In SHIFT with `cnt < WIDTH-1`, the word goes into `hold` and `hold_full` is set.
- Last-bit edge in SHIFT (`cnt == WIDTH-1`):
  - If `hold_full`, `hold` moves into the shifter, `hold_full` clears and `cnt` is set to 0. No accept can coincide with this, because `din_ready` was 0.
  - Else if a word is accepted on this edge, it loads directly into the shifter (see routing above).
  - Otherwise the state moves to IDLE.
- Any other edge in SHIFT: the shifter advances one position and `cnt` increments.
- Output bit order: `sout` takes the shifter MSB when MSB_FIRST=1, and the shifter LSB when MSB_FIRST=0.
- Output values:
  - `sout_valid` = 1 in SHIFT and 0 in IDLE.
  - `sout` is 0 while IDLE.
  - `frame_start` = 1 exactly when SHIFT and `cnt == 0`.
  - `busy` = SHIFT or `hold_full`.
- `din` is ignored when no handshake occurs. `din_valid` may drop at any time without effect.
- Reset (asynchronous, any time, including mid-word):
  - The state goes to IDLE and `cnt`, the shifter, `hold` and `hold_full` all clear.
  - Reset value of every output is 0: `sout`, `sout_valid`, `frame_start`, `busy` and `din_ready`.
  - The partial word in progress and any held word are discarded.

## Timing

- `sout`, `sout_valid`, `frame_start` and `busy` are registered. `din_ready` is combinational from `hold_full` and `rst_n` only; it has no path from `din_valid`.
- Latency: a handshake at edge T from IDLE puts bit 0 on `sout` after edge T. Bit k of the word is presented in the cycle after edge T+k.
- Each word occupies exactly WIDTH consecutive `sout_valid` cycles.
- Throughput: one word per WIDTH cycles. If a next word is present by the last-bit edge, there are zero gap cycles between words.
- After the last bit of the final word, `sout_valid` and `sout` fall to 0 on the next edge.
- `din_ready` returns to 1 in the cycle after `hold` empties.
- Downstream: a `siso` of depth N presents bit k at its `sdo` N cycles after `piso_feeder` presents it on `sout`.

## Test plan

- Reset and idle:
  - Hold `rst_n`=0 for 3 cycles. Expect `sout`, `sout_valid`, `frame_start`, `busy` and `din_ready` all at 0.
  - Release reset. Expect `din_ready`=1 and all other outputs at 0.
- Single word, MSB_FIRST=1, `din`=8'hA5 for one cycle:
  - In the 8 cycles following the handshake, expect `sout` = 1,0,1,0,0,1,0,1.
  - Expect `sout_valid`=1 for those 8 cycles and `frame_start` high on the first only.
  - Then expect IDLE with `sout`=0.
- Back-to-back words 8'hA5 then 8'h3C, `din_valid` held high:
  - Expect 8'h3C to be captured into `hold` one cycle after the first handshake.
  - Expect `din_ready`=0 until the handoff.
  - Expect 16 contiguous `sout_valid` cycles, with `frame_start` high at bit 0 and at bit 8.
- Bit order with MSB_FIRST=0 and `din`=8'h01: expect `sout` = 1,0,0,0,0,0,0,0.
- Accept on the last-bit edge with `hold` empty:
  - Present 8'hFF exactly at `cnt`=7 of word 8'h00.
  - Expect no gap and `frame_start` on the next cycle.
- Reset mid-word:
  - Assert `rst_n`=0 after 3 bits of 8'hFF while `hold` contains 8'h0F.
  - Expect all outputs to be 0 immediately, without waiting for a clock edge.
  - After release, expect no residual bits and `sout_valid`=0 until a new handshake.
